// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding I-cache request, static JAL prediction, and a
// small FIFO of {pc, instruction, c, jump} drained by the decoder.
module instruction_fetch #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [16:0] RESET_PC    = 17'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_en,
  input  logic [16:0] flush_pc,
  output logic        instruction_get_en,
  output logic [16:0] instruction_addr,
  input  logic        instruction_out_en,
  input  logic [31:0] instruction,
  input  logic        c_instruction,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instruction,
  output logic [16:0] fetch_pc,
  output logic        fetch_c,
  output logic        fetch_jump
);

  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(QUEUE_DEPTH);
  localparam logic [6:0]    OPC_JAL = 7'b1101111;

  typedef enum logic {S_REQ, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [16:0]   pc_q, pc_d;
  logic          discard_q, discard_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [16:0] mem_pc  [QUEUE_DEPTH];
  logic [31:0] mem_ins [QUEUE_DEPTH];
  logic        mem_c   [QUEUE_DEPTH];
  logic        mem_j   [QUEUE_DEPTH];

  logic        get_en, resp, push, pop, nonempty, is_jal;
  logic [16:0] jimm, next_pc;

  assign nonempty = (count_q != '0);
  assign get_en   = rst && (state_q == S_REQ) && (count_q < FULL) && !flush_en;
  assign resp     = (state_q == S_WAIT) && instruction_out_en;
  assign push     = resp && !discard_q && !flush_en;
  assign pop      = nonempty && fetch_ready && !flush_en;

  // J-immediate already truncated to the 17-bit PC space: imm[16:12] = inst[16:12].
  assign is_jal  = (instruction[6:0] == OPC_JAL);
  assign jimm    = {instruction[16:12], instruction[20], instruction[30:21], 1'b0};
  assign next_pc = is_jal ? pc_q + jimm : pc_q + (c_instruction ? 17'd2 : 17'd4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_pc[tail_q]  <= pc_q;
      mem_ins[tail_q] <= instruction;
      mem_c[tail_q]   <= c_instruction;
      mem_j[tail_q]   <= is_jal;
    end
  end

  // A flush never changes the state on its own: REQ cannot issue, and WAIT
  // leaves only when the (possibly discarded) response arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (get_en) state_d = S_WAIT;
      S_WAIT:  if (instruction_out_en) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush_en) begin
      pc_d    = flush_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (state_q == S_WAIT) discard_d = !instruction_out_en;
    end else begin
      if (resp) discard_d = 1'b0;
      if (push) begin
        pc_d   = next_pc;
        tail_d = tail_q + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    instruction_get_en = get_en;
    instruction_addr   = rst ? pc_q : '0;
    fetch_valid        = rst && nonempty;
    fetch_pc           = '0;
    fetch_instruction  = '0;
    fetch_c            = 1'b0;
    fetch_jump         = 1'b0;
    if (fetch_valid) begin
      fetch_pc          = mem_pc[head_q];
      fetch_instruction = mem_ins[head_q];
      fetch_c           = mem_c[head_q];
      fetch_jump        = mem_j[head_q];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then randomized traffic,
// every cycle compared against a queue-based behavioural model and a cache stub.
module tb_instruction_fetch;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst, flush_en, instruction_out_en, c_instruction, fetch_ready;
  logic [16:0] flush_pc, instruction_addr, fetch_pc;
  logic [31:0] instruction, fetch_instruction;
  logic        instruction_get_en, fetch_valid, fetch_c, fetch_jump;

  always #5 clk = ~clk;

  instruction_fetch #(.QUEUE_DEPTH(D), .RESET_PC(17'h0)) dut (
    .clk(clk), .rst(rst), .flush_en(flush_en), .flush_pc(flush_pc),
    .instruction_get_en(instruction_get_en), .instruction_addr(instruction_addr),
    .instruction_out_en(instruction_out_en), .instruction(instruction),
    .c_instruction(c_instruction), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc), .fetch_c(fetch_c),
    .fetch_jump(fetch_jump)
  );

  typedef struct packed {
    logic [16:0] pc;
    logic [31:0] ins;
    logic        c;
    logic        j;
  } ent_t;

  ent_t        q[$];
  logic [16:0] m_pc = '0;
  bit          m_wait, m_disc, pend;
  int          cd, lat_fix, rdy_mode;
  bit          rnd_ins, rnd_ctl;
  logic [31:0] fix_ins;
  logic        fix_c;
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] exp_next(input logic [16:0] pc, input logic [31:0] ins,
                                           input logic c, output bit j);
    int imm, p;
    logic [20:0] raw;
    if (ins[6:0] == 7'h6F) begin
      raw = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      imm = int'($signed(raw));
      j   = 1'b1;
    end else begin
      imm = c ? 2 : 4;
      j   = 1'b0;
    end
    p = int'(pc) + imm;
    return p[16:0];
  endfunction

  function automatic bit exp_get();
    return rst && !m_wait && (q.size() < D) && !flush_en;
  endfunction

  function automatic int next_lat();
    return (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 5));
  endfunction

  task automatic drive();
    logic [31:0] r;
    logic [6:0]  op;
    if (rnd_ctl) begin
      rst      = ($urandom_range(0, 199) != 0);
      flush_en = ($urandom_range(0, 15) == 0);
      flush_pc = 17'($urandom);
    end
    case (rdy_mode)
      0:       fetch_ready = 1'($urandom);
      1:       fetch_ready = 1'b1;
      default: fetch_ready = 1'b0;
    endcase
    instruction_out_en = pend && (cd == 0);
    if (rnd_ins) begin
      r  = $urandom;
      op = r[6:0];
      if (op == 7'h6F) op = 7'h13;
      instruction   = {r[31:7], ($urandom_range(0, 2) == 0) ? 7'h6F : op};
      c_instruction = 1'($urandom);
    end else begin
      instruction   = fix_ins;
      c_instruction = fix_c;
    end
  endtask

  task automatic check();
    ent_t h = '0;
    chk("get_en", 64'(instruction_get_en), 64'(exp_get()));
    chk("addr", 64'(instruction_addr), 64'(rst ? m_pc : 17'h0));
    chk("valid", 64'(fetch_valid), 64'(rst && q.size() != 0));
    if (rst && q.size() != 0) h = q[0];
    chk("head", 64'({fetch_pc, fetch_instruction, fetch_c, fetch_jump}), 64'(h));
  endtask

  task automatic model_edge();
    bit   g, pop, j;
    ent_t e;
    g = exp_get();
    if (!rst) begin
      q.delete();
      m_pc = 17'h0; m_wait = 0; m_disc = 0; pend = 0;
    end else begin
      if (instruction_out_en) pend = 0;
      else if (pend && cd > 0) cd--;
      if (flush_en) begin
        q.delete();
        m_pc = flush_pc;
        if (m_wait) begin
          if (instruction_out_en) begin m_wait = 0; m_disc = 0; end
          else m_disc = 1;
        end
      end else begin
        pop = (q.size() != 0) && fetch_ready;
        if (m_wait && instruction_out_en) begin
          if (!m_disc) begin
            e.pc  = m_pc;
            e.ins = instruction;
            e.c   = c_instruction;
            m_pc  = exp_next(m_pc, instruction, c_instruction, j);
            e.j   = j;
            q.push_back(e);
          end
          m_disc = 0;
          m_wait = 0;
        end else if (g) begin
          m_wait = 1;
          pend   = 1;
          cd     = next_lat();
        end
        if (pop) void'(q.pop_front());
      end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 0; flush_en = 0; flush_pc = '0; fetch_ready = 0;
    instruction_out_en = 0; instruction = '0; c_instruction = 0;
    rnd_ins = 0; rnd_ctl = 0; fix_ins = 32'h00100093; fix_c = 0;
    lat_fix = 0; rdy_mode = 1;

    // reset, then sequential hits
    tick(); tick();
    rst = 1; #1;
    chk("issue_after_reset", 64'({instruction_get_en, instruction_addr}), 64'({1'b1, 17'h0}));
    tick(); tick();
    chk("seq_pc0", 64'({fetch_valid, fetch_pc, fetch_jump, instruction_get_en, instruction_addr}),
        64'({1'b1, 17'h0, 1'b0, 1'b1, 17'h4}));
    tick(); tick();
    chk("seq_pc4", 64'({fetch_valid, fetch_pc, fetch_jump, instruction_get_en, instruction_addr}),
        64'({1'b1, 17'h4, 1'b0, 1'b1, 17'h8}));

    // compressed wrap at the top of the PC space
    flush_en = 1; flush_pc = 17'h1FFFE; tick(); flush_en = 0; #1;
    chk("flush_req", 64'({fetch_valid, instruction_get_en, instruction_addr}),
        64'({1'b0, 1'b1, 17'h1FFFE}));
    fix_c = 1; tick(); tick();
    chk("wrap", 64'({fetch_pc, fetch_c, instruction_addr}), 64'({17'h1FFFE, 1'b1, 17'h0}));

    // JAL forward and backward
    fix_c = 0; fix_ins = 32'h0100006F;
    flush_en = 1; flush_pc = 17'h100; tick(); flush_en = 0;
    tick(); tick();
    chk("jal_fwd", 64'({fetch_pc, fetch_jump, instruction_addr}), 64'({17'h100, 1'b1, 17'h110}));
    fix_ins = 32'hFF1FF06F; tick(); tick();
    chk("jal_back", 64'({fetch_pc, fetch_jump, instruction_addr}), 64'({17'h110, 1'b1, 17'h100}));

    // FIFO full stall and single pop
    fix_ins = 32'h00100093; rdy_mode = 2;
    flush_en = 1; flush_pc = 17'h200; tick(); flush_en = 0;
    repeat (8) tick();
    chk("full_stall", 64'({instruction_get_en, fetch_valid, fetch_pc}), 64'({1'b0, 1'b1, 17'h200}));
    repeat (2) tick();
    chk("full_hold", 64'(instruction_get_en), 64'(1'b0));
    rdy_mode = 1; tick(); rdy_mode = 2;
    chk("one_pop", 64'({instruction_get_en, instruction_addr, fetch_pc}),
        64'({1'b1, 17'h210, 17'h204}));

    // flush during a miss
    rdy_mode = 1; lat_fix = 5;
    flush_en = 1; flush_pc = 17'h20; tick(); flush_en = 0;
    tick();
    flush_en = 1; flush_pc = 17'h80; lat_fix = 0; tick(); flush_en = 0;
    repeat (5) tick();
    chk("discard", 64'({instruction_get_en, instruction_addr, fetch_valid}),
        64'({1'b1, 17'h80, 1'b0}));
    tick(); tick();
    chk("post_flush", 64'({fetch_valid, fetch_pc}), 64'({1'b1, 17'h80}));

    // flush coinciding with a response and a pop, two entries queued
    rdy_mode = 2;
    flush_en = 1; flush_pc = 17'h300; tick(); flush_en = 0;
    repeat (5) tick();
    flush_en = 1; flush_pc = 17'h40; rdy_mode = 1; tick(); flush_en = 0; rdy_mode = 2; #1;
    chk("flush_resp", 64'({fetch_valid, instruction_get_en, instruction_addr}),
        64'({1'b0, 1'b1, 17'h40}));
    tick(); tick();
    chk("flush_resp_push", 64'({fetch_valid, fetch_pc}), 64'({1'b1, 17'h40}));

    // randomized traffic: random latency, backpressure, flushes and resets
    rnd_ins = 1; rnd_ctl = 1; rdy_mode = 0; lat_fix = -1;
    repeat (3000) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch stage. Holds the program counter and issues one request at a time to the instruction cache. Accepts the cache's decompressed 32-bit instruction and its compressed flag, computes the next PC (sequential, or statically predicted JAL), and buffers `{pc, instruction, c, jump}` in a small FIFO that the decoder drains with a valid/ready handshake. A redirect from the back end flushes the FIFO and discards any in-flight response.

## Interface
- `QUEUE_DEPTH`, default 4: FIFO entries; must be a power of 2, ≥ 2.
- `RESET_PC`, default 17'h0: PC loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (`rst==0` resets on the next rising edge).
- `flush_en`  in  1  redirect request from the back end.
- `flush_pc`  in  17  redirect target PC.
- `instruction_get_en`  out  1  cache request strobe.
- `instruction_addr`  out  17  cache request address (equals `pc`).
- `instruction_out_en`  in  1  one-cycle pulse: cache response valid.
- `instruction`  in  32  decompressed instruction.
- `c_instruction`  in  1  1 if the original instruction was 16-bit.
- `fetch_valid`  out  1  FIFO non-empty.
- `fetch_ready`  in  1  decoder accepts the head entry.
- `fetch_instruction`  out  32  head instruction.
- `fetch_pc`  out  17  head PC.
- `fetch_c`  out  1  head compressed flag.
- `fetch_jump`  out  1  head was predicted as a taken JAL.

## Operation
- State: `pc` (17 b), FSM {REQ, WAIT}, `discard` flag, FIFO (head/tail pointers, count 0..QUEUE_DEPTH).
- Reset: FSM=REQ, `pc`=RESET_PC, count=0, `discard`=0. All outputs are 0 while `rst==0`.
- `instruction_get_en` is combinational: `rst && state==REQ && count<QUEUE_DEPTH && !flush_en`. `instruction_addr` = `pc`.
- REQ: when `instruction_get_en`=1, go to WAIT. Otherwise stay in REQ. At most one request is outstanding, and a FIFO slot is guaranteed free for its response.
- WAIT: `instruction_get_en`=0 and the FSM waits for `instruction_out_en`.
  - If `discard`=0, push `{pc, instruction, c_instruction, jump}`, set `pc`←next_pc, and go to REQ.
  - If `discard`=1, drop the response, clear `discard`, and go to REQ (`pc` already holds the redirect target).
- next_pc:
  - If `instruction[6:0]==7'b1101111` (JAL, including decompressed c.j/c.jal): `pc + J-imm`, with J-imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}) truncated to 17 bits; `jump`=1.
  - Otherwise `pc+2` if `c_instruction`, else `pc+4`; `jump`=0.
  - All PC arithmetic is mod 2^17 (wraps).
- Flush (`flush_en`=1) has the highest priority:
  - FIFO is cleared (count=0; a simultaneous pop is ignored) and `pc`←`flush_pc`.
  - In REQ: no request is issued this cycle; stay in REQ.
  - In WAIT with no response this cycle: set `discard`=1 and stay in WAIT.
  - In WAIT with a response this cycle: drop it, clear `discard`, go to REQ.
  - Repeated flushes while `discard`=1 only update `pc`.
- FIFO:
  - `fetch_valid` = (count≠0). Head fields are driven to 0 when empty.
  - Pop when `fetch_valid && fetch_ready && !flush_en`. Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- The cache shares the reset, so no response is in flight after reset.

## Timing
- Issue: `instruction_get_en` rises in the first cycle after `rst` deasserts.
- Cache hit: the response arrives the cycle after the request, and the entry is visible at `fetch_valid` the following cycle. Steady-state throughput is 1 instruction per 2 cycles on hits.
- Miss: WAIT holds for any number of cycles; `instruction_get_en` stays 0 throughout.
- Full FIFO: REQ stalls, and issue resumes the cycle after a pop makes count<QUEUE_DEPTH.
- Flush: `fetch_valid`=0 the cycle after `flush_en`. The first request to `flush_pc` is issued:
  - the cycle after the flush, if in REQ or if a response coincided with the flush;
  - otherwise the cycle after the discarded response.

## Test plan
- Sequential hits: reset with RESET_PC=0, cache returns 32-bit `addi` (c=0) 1 cycle after each request, `fetch_ready`=1 → requests to 0x0, 0x4, 0x8, each 2 cycles apart; decoder sees pcs 0, 4, 8 with `fetch_jump`=0.
- Compressed and wrap: pc=0x1FFFE with a c=1 response → next request address 0x00000.
- JAL prediction: at pc 0x100 return `instruction`=32'h0100006F (jal x0,+16) → next request 0x110, entry `fetch_jump`=1. Then return 32'hFF1FF06F (jal -16) → next request 0x100.
- FIFO full: `fetch_ready`=0, QUEUE_DEPTH=4 → after 4 pushes `instruction_get_en` stays 0. Raise `fetch_ready` for 1 cycle → exactly one pop, and a new request the next cycle.
- Flush during miss: request 0x20 outstanding, pulse `flush_en` with `flush_pc`=0x80, then return a response 5 cycles later → response dropped, FIFO empty, next request 0x80, first pushed entry has pc 0x80.
- Flush coincident with response and pop: `flush_en`=1 in the same cycle as `instruction_out_en` and `fetch_ready` with 2 entries queued → count=0, nothing pushed, request to `flush_pc` the next cycle.
